// File: rtl/arm_code_emitter_pkg.sv
// arm_code_emitter_pkg: emit kinds, flush FSM states and the immediate-patch helper
// shared by the ARM code emitter and its testbench.
package arm_code_emitter_pkg;

    localparam int CRAM_AW_DEFAULT = 10;

    typedef enum logic [1:0] {
        EMIT_K_WORD  = 2'b00,
        EMIT_K_IMM8  = 2'b01,
        EMIT_K_HI    = 2'b10,
        EMIT_K_IMM16 = 2'b11
    } emit_kind_e;

    typedef enum logic [1:0] {
        EMIT_RUN   = 2'b00,
        EMIT_FLUSH = 2'b01,
        EMIT_DONE  = 2'b10
    } emit_state_e;

    // IMM8 is a MOV with rotate 0; IMM16 scatters hi:lo into the MOVW imm4/imm12 fields.
    function automatic logic [31:0] emit_patch(input emit_kind_e kind, input logic [31:0] data,
                                               input logic [7:0] lo, input logic [7:0] hi);
        return kind == EMIT_K_IMM8  ? {data[31:12], 4'h0, lo} :
               kind == EMIT_K_IMM16 ? {data[31:20], hi[7:4], data[15:12], hi[3:0], lo} :
               data;
    endfunction

endpackage

// File: rtl/arm_code_emitter_if.sv
// arm_code_emitter_if: sequencer emit path plus code RAM write port of the emitter.
interface arm_code_emitter_if #(parameter int CRAM_AW = 10);
    import arm_code_emitter_pkg::*;

    logic               in_valid;
    emit_kind_e         in_kind;
    logic [31:0]        in_data;
    logic [7:0]         in_byte;
    logic               flush;
    logic               waiting;
    logic               cram_we;
    logic [CRAM_AW-1:0] cram_adr;
    logic [31:0]        cram_wdata;
    logic               cram_ready;
    logic [CRAM_AW:0]   emit_count;
    logic               overflow;
    logic               flush_done;

    modport master (
        output in_valid, in_kind, in_data, in_byte, flush, cram_ready,
        input  waiting, cram_we, cram_adr, cram_wdata, emit_count, overflow, flush_done
    );

    modport slave (
        input  in_valid, in_kind, in_data, in_byte, flush, cram_ready,
        output waiting, cram_we, cram_adr, cram_wdata, emit_count, overflow, flush_done
    );

endinterface

// File: rtl/emit_fifo.sv
// emit_fifo: power-of-two circular FIFO holding patched ARM words awaiting RAM commit.
module emit_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic             wr, rd;

    assign wr    = push && !full;
    assign rd    = pop && !empty;
    assign dout  = mem[rd_ptr];
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;

    always_ff @(posedge clk)
        if (wr) mem[wr_ptr] <= din;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr) - (AW+1)'(rd);
        end

endmodule

// File: rtl/arm_code_emitter.sv
// arm_code_emitter: patches JVM immediates into ARM templates, buffers them and writes
// them sequentially into the code RAM, with flush handshake and sticky RAM-full overflow.
module arm_code_emitter
    import arm_code_emitter_pkg::*;
#(
    parameter int CRAM_AW    = CRAM_AW_DEFAULT,
    parameter int FIFO_DEPTH = 4,
    parameter int BASE_ADR   = 0
) (
    input logic                clk,
    input logic                reset,
    arm_code_emitter_if.slave  bus
);

    localparam int                 CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CRAM_AW-1:0] BASE  = CRAM_AW'(BASE_ADR);
    localparam logic [CRAM_AW-1:0] ONE_A = 1;
    localparam logic [CRAM_AW:0]   ONE_C = 1;

    emit_state_e   state;
    logic [7:0]    hi_byte;
    logic [31:0]   head, patched;
    logic [CW-1:0] fifo_count;
    logic          full, empty, accept, push, pop, commit;

    assign accept  = bus.in_valid && !bus.waiting;
    assign push    = accept && bus.in_kind != EMIT_K_HI && !full;
    assign patched = emit_patch(bus.in_kind, bus.in_data, bus.in_byte, hi_byte);
    assign commit  = bus.cram_we && bus.cram_ready;
    // After overflow the head is discarded every cycle so the sequencer never stalls.
    assign pop     = commit || (bus.overflow && !empty);

    assign bus.waiting    = fifo_count == CW'(FIFO_DEPTH) || state != EMIT_RUN;
    assign bus.cram_we    = !empty && !bus.overflow;
    assign bus.cram_wdata = head;
    assign bus.overflow   = bus.emit_count[CRAM_AW];

    emit_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (patched),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // cram_adr stops on the last RAM word once the final commit sets overflow.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state          <= EMIT_RUN;
            hi_byte        <= '0;
            bus.emit_count <= '0;
            bus.cram_adr   <= BASE;
            bus.flush_done <= 1'b0;
        end else begin
            state <= state == EMIT_RUN   ? (bus.flush ? EMIT_FLUSH : EMIT_RUN) :
                     state == EMIT_FLUSH ? (empty ? EMIT_DONE : EMIT_FLUSH) :
                     EMIT_RUN;
            hi_byte <= (state == EMIT_RUN && bus.flush) ? 8'h00 :
                       !accept                          ? hi_byte :
                       bus.in_kind == EMIT_K_HI         ? bus.in_byte :
                       bus.in_kind == EMIT_K_IMM16      ? 8'h00 :
                       hi_byte;
            bus.flush_done <= state == EMIT_FLUSH && empty;
            if (commit) bus.emit_count <= bus.emit_count + ONE_C;
            if (commit && bus.emit_count[CRAM_AW-1:0] != '1) bus.cram_adr <= bus.cram_adr + ONE_A;
        end

endmodule

// File: tb/tb_arm_code_emitter.sv
// tb_arm_code_emitter: directed scenarios for the emitter; a 10-bit instance for the main
// paths and a 2-bit instance to reach code RAM exhaustion quickly.
module tb_arm_code_emitter;
    import arm_code_emitter_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] a_dat [16];
    logic [9:0]  a_adr [16];
    int          a_n = 0;
    logic [31:0] b_dat [16];
    logic [1:0]  b_adr [16];
    int          b_n = 0;

    always #5 clk = ~clk;

    arm_code_emitter_if #(.CRAM_AW(10)) ia ();
    arm_code_emitter_if #(.CRAM_AW(2))  ib ();

    arm_code_emitter #(.CRAM_AW(10), .FIFO_DEPTH(4), .BASE_ADR(0)) ua (.clk(clk), .reset(reset), .bus(ia));
    arm_code_emitter #(.CRAM_AW(2),  .FIFO_DEPTH(4), .BASE_ADR(0)) ub (.clk(clk), .reset(reset), .bus(ib));

    // Write log: a write offered at the falling edge commits on the next rising edge.
    always @(negedge clk) begin
        if (reset && ia.cram_we && ia.cram_ready && a_n < 16) begin
            a_adr[a_n] = ia.cram_adr;
            a_dat[a_n] = ia.cram_wdata;
            a_n++;
        end
        if (reset && ib.cram_we && ib.cram_ready && b_n < 16) begin
            b_adr[b_n] = ib.cram_adr;
            b_dat[b_n] = ib.cram_wdata;
            b_n++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ia.in_valid = 1'b0; ia.in_kind = EMIT_K_WORD; ia.in_data = '0; ia.in_byte = '0;
        ia.flush = 1'b0; ia.cram_ready = 1'b0;
        ib.in_valid = 1'b0; ib.in_kind = EMIT_K_WORD; ib.in_data = '0; ib.in_byte = '0;
        ib.flush = 1'b0; ib.cram_ready = 1'b0;
    endtask

    task automatic apply_reset;
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        a_n = 0;
        b_n = 0;
    endtask

    task automatic send_a(input emit_kind_e k, input logic [31:0] d, input logic [7:0] b);
        ia.in_valid = 1'b1; ia.in_kind = k; ia.in_data = d; ia.in_byte = b;
        tick();
        ia.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset();
        checks++; if (ia.waiting !== 1'b0) begin errors++; $display("FAIL rst_waiting got %0h want 0", ia.waiting); end
        checks++; if (ia.cram_we !== 1'b0) begin errors++; $display("FAIL rst_we got %0h want 0", ia.cram_we); end
        checks++; if (ia.cram_adr !== 10'd0) begin errors++; $display("FAIL rst_adr got %0h want 0", ia.cram_adr); end
        checks++; if (ia.emit_count !== 11'd0) begin errors++; $display("FAIL rst_count got %0h want 0", ia.emit_count); end
        checks++; if (ia.overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %0h want 0", ia.overflow); end
        checks++; if (ia.flush_done !== 1'b0) begin errors++; $display("FAIL rst_flush_done got %0h want 0", ia.flush_done); end
    endtask

    task automatic test_word;
        apply_reset();
        ia.cram_ready = 1'b1;
        send_a(EMIT_K_WORD, 32'hE1A00000, 8'h00);
        checks++; if (ia.cram_we !== 1'b1) begin errors++; $display("FAIL word_we got %0h want 1", ia.cram_we); end
        checks++; if (ia.cram_adr !== 10'd0) begin errors++; $display("FAIL word_adr got %0h want 0", ia.cram_adr); end
        checks++; if (ia.cram_wdata !== 32'hE1A00000) begin errors++; $display("FAIL word_wdata got %h want e1a00000", ia.cram_wdata); end
        tick();
        checks++; if (ia.emit_count !== 11'd1) begin errors++; $display("FAIL word_count got %0d want 1", ia.emit_count); end
        checks++; if (ia.cram_we !== 1'b0) begin errors++; $display("FAIL word_we_after got %0h want 0", ia.cram_we); end
        checks++; if (ia.cram_adr !== 10'd1) begin errors++; $display("FAIL word_adr_after got %0h want 1", ia.cram_adr); end
    endtask

    task automatic test_patch;
        apply_reset();
        ia.cram_ready = 1'b1;
        send_a(EMIT_K_HI, 32'h0, 8'h12);
        checks++; if (ia.cram_we !== 1'b0) begin errors++; $display("FAIL hi_no_enqueue got %0h want 0", ia.cram_we); end
        send_a(EMIT_K_IMM16, 32'hE3000000, 8'h34);
        checks++; if (ia.cram_wdata !== 32'hE3010234) begin errors++; $display("FAIL imm16_wdata got %h want e3010234", ia.cram_wdata); end
        send_a(EMIT_K_IMM16, 32'hE3000000, 8'h05);
        checks++; if (ia.cram_wdata !== 32'hE3000005) begin errors++; $display("FAIL imm16_hi_cleared got %h want e3000005", ia.cram_wdata); end
        checks++; if (ia.cram_adr !== 10'd1) begin errors++; $display("FAIL imm16_adr got %0h want 1", ia.cram_adr); end
        send_a(EMIT_K_IMM8, 32'hE3A01FFF, 8'h7F);
        checks++; if (ia.cram_wdata !== 32'hE3A0107F) begin errors++; $display("FAIL imm8_wdata got %h want e3a0107f", ia.cram_wdata); end
        tick();
        checks++; if (ia.emit_count !== 11'd3) begin errors++; $display("FAIL patch_count got %0d want 3", ia.emit_count); end
    endtask

    task automatic test_back_to_back;
        apply_reset();
        ia.cram_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ia.in_valid = 1'b1; ia.in_kind = EMIT_K_WORD; ia.in_data = 32'hA0000000 + i;
            tick();
            if (i == 2) begin
                checks++; if (ia.waiting !== 1'b0) begin errors++; $display("FAIL bp_wait3 got %0h want 0", ia.waiting); end
            end
            if (i == 3) begin
                checks++; if (ia.waiting !== 1'b1) begin errors++; $display("FAIL bp_wait4 got %0h want 1", ia.waiting); end
            end
        end
        ia.in_valid = 1'b0;
        checks++; if (ia.emit_count !== 11'd0) begin errors++; $display("FAIL bp_no_commit got %0d want 0", ia.emit_count); end
        ia.cram_ready = 1'b1;
        repeat (6) tick();
        checks++; if (a_n !== 4) begin errors++; $display("FAIL bp_writes got %0d want 4", a_n); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (a_adr[i] !== 10'(i) || a_dat[i] !== 32'hA0000000 + i)
                begin errors++; $display("FAIL bp_entry%0d got %0h:%h want %0h:%h", i, a_adr[i], a_dat[i], i, 32'hA0000000 + i); end
        end
        checks++; if (ia.waiting !== 1'b0) begin errors++; $display("FAIL bp_wait_end got %0h want 0", ia.waiting); end
    endtask

    task automatic test_flush;
        bit found = 0;
        int pulses = 0;
        apply_reset();
        ia.cram_ready = 1'b0;
        send_a(EMIT_K_WORD, 32'hB0000000, 8'h00);
        send_a(EMIT_K_WORD, 32'hB0000001, 8'h00);
        ia.flush = 1'b1;
        send_a(EMIT_K_WORD, 32'hB0000002, 8'h00);
        ia.flush = 1'b0;
        checks++; if (ia.waiting !== 1'b1) begin errors++; $display("FAIL flush_waiting got %0h want 1", ia.waiting); end
        ia.cram_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (ia.flush_done === 1'b1) begin found = 1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL flush_timeout got none want pulse"); end
        checks++; if (a_n !== 3 || a_dat[2] !== 32'hB0000002)
            begin errors++; $display("FAIL flush_drained got %0d/%h want 3/b0000002", a_n, a_dat[2]); end
        tick();
        checks++; if (ia.waiting !== 1'b0) begin errors++; $display("FAIL flush_wait_after got %0h want 0", ia.waiting); end
        for (int k = 0; k < 5; k++) begin
            if (ia.flush_done === 1'b1) pulses++;
            tick();
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL flush_extra_pulse got %0d want 0", pulses); end
        checks++; if (ia.emit_count !== 11'd3) begin errors++; $display("FAIL flush_count got %0d want 3", ia.emit_count); end
    endtask

    task automatic test_overflow;
        apply_reset();
        ib.cram_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ib.in_valid = 1'b1; ib.in_kind = EMIT_K_WORD; ib.in_data = 32'hC0000000 + i;
            tick();
        end
        ib.in_valid = 1'b0;
        checks++; if (ib.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0h want 1", ib.overflow); end
        repeat (3) tick();
        checks++; if (b_n !== 4) begin errors++; $display("FAIL ovf_writes got %0d want 4", b_n); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (b_adr[i] !== 2'(i) || b_dat[i] !== 32'hC0000000 + i)
                begin errors++; $display("FAIL ovf_entry%0d got %0h:%h want %0h:%h", i, b_adr[i], b_dat[i], i, 32'hC0000000 + i); end
        end
        checks++; if (ib.emit_count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", ib.emit_count); end
        checks++; if (ib.cram_we !== 1'b0) begin errors++; $display("FAIL ovf_we got %0h want 0", ib.cram_we); end
        checks++; if (ib.cram_adr !== 2'd3) begin errors++; $display("FAIL ovf_adr_frozen got %0h want 3", ib.cram_adr); end
        ib.in_valid = 1'b1; ib.in_data = 32'hC0000009;
        tick();
        ib.in_valid = 1'b0;
        checks++; if (ib.cram_we !== 1'b0 || ib.waiting !== 1'b0)
            begin errors++; $display("FAIL ovf_discard got we=%0h wait=%0h want 0/0", ib.cram_we, ib.waiting); end
        ib.cram_ready = 1'b0;
        ia.cram_ready = 1'b0;
        send_a(EMIT_K_WORD, 32'hD0000000, 8'h00);
        #3 reset = 1'b0;
        #1;
        checks++; if (ib.overflow !== 1'b0 || ib.emit_count !== 3'd0 || ib.cram_adr !== 2'd0)
            begin errors++; $display("FAIL mid_rst_b got ovf=%0h cnt=%0d adr=%0h want 0/0/0", ib.overflow, ib.emit_count, ib.cram_adr); end
        checks++; if (ia.cram_we !== 1'b0 || ia.waiting !== 1'b0 || ia.flush_done !== 1'b0)
            begin errors++; $display("FAIL mid_rst_a got we=%0h wait=%0h done=%0h want 0/0/0", ia.cram_we, ia.waiting, ia.flush_done); end
        tick();
        reset = 1'b1;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_word();
        test_patch();
        test_back_to_back();
        test_flush();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
